// File: rtl/bus_cmd_bridge.sv
// bus_cmd_bridge: UART byte-frame to parallel peripheral bus bridge (CMD, ADDR, data -> strobed access -> reply).
// Optional inter-byte timeout is compiled in when BRIDGE_TIMEOUT_EN is defined.

// state    | meaning
// IDLE     | waiting for a CMD byte
// GETADDR  | waiting for the ADDR byte
// GETDATA  | collecting N write data bytes, LSB first
// SETUP    | address/rw/write data on the bus, select low (1 cycle)
// STROBE   | select high, first SEL_HOLD-1 cycles
// SAMPLE   | last select-high cycle; read data and size captured
// REPLY    | reply bytes handed to the transmitter one per handshake

module bus_cmd_bridge #(
  parameter int SEL_HOLD = 4,
  parameter int TIMEOUT  = 120000
) (
  input  logic        clk_12MHz,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  inout  wire  [31:0] databus,
  output logic [7:0]  register_addr,
  output logic        rw,
  output logic        select,
  input  logic [2:0]  reg_size
);

  localparam logic [7:0] REPLY_WR_OK   = 8'hA5;
  localparam logic [7:0] REPLY_BAD_CMD = 8'hEE;
  localparam logic [7:0] REPLY_NO_REG  = 8'h00;

  if (SEL_HOLD < 3 || SEL_HOLD > 15 || TIMEOUT < 2) begin : g_param_check
    $error("bus_cmd_bridge: SEL_HOLD or TIMEOUT out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GETADDR,
    S_GETDATA,
    S_SETUP,
    S_STROBE,
    S_SAMPLE,
    S_REPLY
  } state_t;

  state_t      r_state;
  logic        r_is_read;
  logic [2:0]  r_len;
  logic [1:0]  r_idx;
  logic [31:0] r_wdata;
  logic        r_drive;
  logic [3:0]  r_hold;
  logic [7:0]  r_addr;
  logic        r_rw;
  logic        r_select;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [31:0] r_tx_buf;
  logic [2:0]  r_tx_left;
  logic        w_gap_expired;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT + 1);
  logic [GW-1:0] r_gap;

  // Gap timer reloads on every accepted frame byte and only runs mid-frame.
  always_ff @(posedge clk_12MHz or negedge resetn) begin
    if (!resetn) begin
      r_gap <= '0;
    end else if (rx_valid && (r_state == S_IDLE || r_state == S_GETADDR ||
                              r_state == S_GETDATA)) begin
      r_gap <= GW'(TIMEOUT - 1);
    end else if ((r_state == S_GETADDR || r_state == S_GETDATA) && r_gap != '0) begin
      r_gap <= r_gap - GW'(1);
    end
  end

  assign w_gap_expired = (r_gap == '0);
`else
  assign w_gap_expired = 1'b0;
`endif

  always_ff @(posedge clk_12MHz or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_is_read  <= 1'b0;
      r_len      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_drive    <= 1'b0;
      r_hold     <= '0;
      r_addr     <= '0;
      r_rw       <= 1'b1;
      r_select   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_buf   <= '0;
      r_tx_left  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_is_read <= rx_data[7];
            r_len     <= rx_data[2:0];
            r_wdata   <= '0;
            r_idx     <= '0;
            r_state   <= S_GETADDR;
          end
        end

        S_GETADDR: begin
          if (rx_valid) begin
            r_addr <= rx_data;
            if (r_is_read) begin
              r_rw    <= 1'b1;
              r_state <= S_SETUP;
            end else if (r_len >= 3'd1 && r_len <= 3'd4) begin
              r_state <= S_GETDATA;
            end else begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= REPLY_BAD_CMD;
              r_tx_left  <= '0;
              r_state    <= S_REPLY;
            end
          end else if (w_gap_expired) begin
            r_state <= S_IDLE;
          end
        end

        S_GETDATA: begin
          if (rx_valid) begin
            case (r_idx)
              2'd0:    r_wdata[7:0]   <= rx_data;
              2'd1:    r_wdata[15:8]  <= rx_data;
              2'd2:    r_wdata[23:16] <= rx_data;
              default: r_wdata[31:24] <= rx_data;
            endcase
            if ({1'b0, r_idx} == r_len - 3'd1) begin
              r_rw    <= 1'b0;
              r_drive <= 1'b1;
              r_state <= S_SETUP;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_gap_expired) begin
            r_state <= S_IDLE;
          end
        end

        S_SETUP: begin
          r_select <= 1'b1;
          r_hold   <= 4'(SEL_HOLD - 2);
          r_state  <= S_STROBE;
        end

        // SAMPLE is itself the final select-high cycle, so STROBE covers SEL_HOLD-1.
        S_STROBE: begin
          if (r_hold == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_hold <= r_hold - 4'd1;
          end
        end

        S_SAMPLE: begin
          r_select   <= 1'b0;
          r_drive    <= 1'b0;
          r_tx_valid <= 1'b1;
          r_state    <= S_REPLY;
          if (!r_is_read) begin
            r_tx_data <= REPLY_WR_OK;
            r_tx_left <= '0;
          end else if (reg_size >= 3'd1 && reg_size <= 3'd4) begin
            r_tx_data <= {5'b0, reg_size};
            r_tx_buf  <= databus;
            r_tx_left <= reg_size;
          end else begin
            r_tx_data <= REPLY_NO_REG;
            r_tx_left <= '0;
          end
        end

        S_REPLY: begin
          if (tx_ready) begin
            if (r_tx_left == 3'd0) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_data <= r_tx_buf[7:0];
              r_tx_buf  <= {8'h00, r_tx_buf[31:8]};
              r_tx_left <= r_tx_left - 3'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign databus       = r_drive ? r_wdata : {32{1'bz}};
  assign register_addr = r_addr;
  assign rw            = r_rw;
  assign select        = r_select;
  assign tx_data       = r_tx_data;
  assign tx_valid      = r_tx_valid;

endmodule

// File: tb/tb_bus_cmd_bridge.sv
// tb_bus_cmd_bridge: directed frames against bus_cmd_bridge with a small peripheral and bus probe.
// With BRIDGE_TIMEOUT_EN the gap limit is scaled down to keep the run short.

module tb_bus_cmd_bridge;

  localparam int SEL_HOLD = 4;
`ifdef BRIDGE_TIMEOUT_EN
  localparam int TMO = 1200;
`else
  localparam int TMO = 120000;
`endif

  logic        clk_12MHz = 1'b0;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  wire  [31:0] databus;
  logic [7:0]  register_addr;
  logic        rw;
  logic        select;
  logic [2:0]  periph_size;

  logic [31:0] periph_data;
  logic        probe_en;
  logic [31:0] probe_val;

  int n_err = 0;
  int n_chk = 0;

  bus_cmd_bridge #(.SEL_HOLD(SEL_HOLD), .TIMEOUT(TMO)) dut (
    .clk_12MHz    (clk_12MHz),
    .resetn       (resetn),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .databus      (databus),
    .register_addr(register_addr),
    .rw           (rw),
    .select       (select),
    .reg_size     (periph_size)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  // Peripheral answers reads during select; otherwise the probe value shows whether the DUT let go.
  assign databus = (select && rw) ? periph_data : (probe_en ? probe_val : {32{1'bz}});

  logic [7:0]  rq[$];
  int          bus_clash = 0;
  int          pulses = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          unstable = 0;
  logic        prev_sel = 1'b0;
  logic [7:0]  prev_addr = '0, h_addr = '0, s_addr = '0;
  logic        prev_rw = 1'b1, h_rw = 1'b1, s_rw = 1'b1;
  logic [31:0] prev_bus = '0, h_bus = '0, s_bus = '0;

  always @(negedge clk_12MHz) begin
    if (tx_valid && tx_ready) rq.push_back(tx_data);
    if (probe_en && !(select && rw) && databus !== probe_val) bus_clash++;
    if (select && !prev_sel) begin
      s_addr = prev_addr; s_rw = prev_rw; s_bus = prev_bus;
      h_addr = register_addr; h_rw = rw; h_bus = databus;
      cur_len = 1;
    end else if (select) begin
      cur_len++;
      if (register_addr !== h_addr || rw !== h_rw || databus !== h_bus) unstable++;
    end else if (prev_sel) begin
      last_len = cur_len;
      pulses++;
    end
    prev_sel = select; prev_addr = register_addr; prev_rw = rw; prev_bus = databus;
  end

  task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_12MHz);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_12MHz);
    rx_valid = 1'b0;
  endtask

  // Changes that the negedge monitor reads are made just after a rising edge.
  task automatic set_ready(input logic v);
    @(posedge clk_12MHz);
    #1 tx_ready = v;
  endtask

  task automatic set_probe(input logic v);
    @(posedge clk_12MHz);
    #1 probe_en = v;
  endtask

  task automatic expect_reply(input string tag, input int n, input logic [39:0] exp);
    for (int i = 0; i < 400; i++) begin
      if (rq.size() >= n && !tx_valid) break;
      @(negedge clk_12MHz);
    end
    repeat (5) @(negedge clk_12MHz);
    check({tag, "_len"}, 40'(rq.size()), 40'(n));
    for (int k = 0; k < n; k++)
      if (k < rq.size()) check($sformatf("%s_b%0d", tag, k), 40'(rq[k]), 40'(exp[k*8 +: 8]));
    rq.delete();
  endtask

  task automatic wait_tx_valid(input string tag);
    int i;
    for (i = 0; i < 100 && !tx_valid; i++) @(negedge clk_12MHz);
    check({tag, "_txv_seen"}, 40'(tx_valid), 40'd1);
  endtask

  task automatic write_frame(input string tag, input logic [7:0] addr, input logic [31:0] d,
                             input int n, input logic [31:0] exp_bus);
    int p0;
    p0 = pulses;
    send_byte(8'(n));
    send_byte(addr);
    for (int k = 0; k < n; k++) send_byte(d[k*8 +: 8]);
    expect_reply({tag, "_rep"}, 1, 40'hA5);
    check({tag, "_addr"}, 40'(s_addr), 40'(addr));
    check({tag, "_rw"}, 40'(s_rw), 40'd0);
    check({tag, "_bus"}, 40'(s_bus), 40'(exp_bus));
    check({tag, "_pulses"}, 40'(pulses - p0), 40'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    periph_data = '0; periph_size = '0; probe_en = 1'b1; probe_val = 32'h5A5A5A5A;
    repeat (3) @(negedge clk_12MHz);
    check("rst_select", 40'(select), 40'd0);
    check("rst_rw", 40'(rw), 40'd1);
    check("rst_addr", 40'(register_addr), 40'd0);
    check("rst_txv", 40'(tx_valid), 40'd0);
    check("rst_txd", 40'(tx_data), 40'd0);
    check("rst_bus_z", 40'(databus), 40'h5A5A5A5A);
    resetn = 1'b1;
    repeat (2) @(negedge clk_12MHz);

    // 4-byte write
    set_probe(1'b0);
    unstable = 0;
    write_frame("wr4", 8'h12, 32'h12345678, 4, 32'h12345678);
    check("wr4_sel_len", 40'(last_len), 40'(SEL_HOLD));
    check("wr4_stable", 40'(unstable), 40'd0);
    set_probe(1'b1);
    bus_clash = 0;
    @(negedge clk_12MHz);
    check("wr4_release", 40'(databus), 40'h5A5A5A5A);

    // 4-byte read
    periph_data = 32'hDEADBEEF; periph_size = 3'd4;
    send_byte(8'h80); send_byte(8'h13);
    expect_reply("rd4", 5, 40'hDEADBEEF04);
    check("rd4_addr", 40'(s_addr), 40'h13);
    check("rd4_rw", 40'(s_rw), 40'd1);
    check("rd4_setup_z", 40'(s_bus), 40'h5A5A5A5A);
    check("rd4_sel_len", 40'(last_len), 40'(SEL_HOLD));

    // missing register, oversize register, 1-byte register
    periph_data = 32'h01020304; periph_size = 3'd0;
    send_byte(8'h80); send_byte(8'h7F);
    expect_reply("rd0", 1, 40'h00);
    periph_size = 3'd5;
    send_byte(8'h80); send_byte(8'h21);
    expect_reply("rd5", 1, 40'h00);
    periph_data = 32'h123456C3; periph_size = 3'd1;
    send_byte(8'h80); send_byte(8'h22);
    expect_reply("rd1", 2, 40'hC301);
    check("rd_bus_clash", 40'(bus_clash), 40'd0);

    // bad write lengths: no bus access
    p0 = pulses;
    send_byte(8'h05); send_byte(8'h20);
    expect_reply("bad5", 1, 40'hEE);
    send_byte(8'h00); send_byte(8'h20);
    expect_reply("bad0", 1, 40'hEE);
    check("bad_no_sel", 40'(pulses - p0), 40'd0);

    // stalled reply with a stray rx byte; the stray byte must not start a frame
    periph_data = 32'h0000BEEF; periph_size = 3'd2;
    set_ready(1'b0);
    send_byte(8'h80); send_byte(8'h55);
    wait_tx_valid("stall");
    send_byte(8'h81);
    repeat (20) @(negedge clk_12MHz);
    check("stall_txd", 40'(tx_data), 40'h02);
    check("stall_txv", 40'(tx_valid), 40'd1);
    set_ready(1'b1);
    expect_reply("stall", 3, 40'hBEEF02);
    set_probe(1'b0);
    write_frame("wr1", 8'h22, 32'h000000C3, 1, 32'h000000C3);
    set_probe(1'b1);

    // reset during a stalled read reply
    periph_data = 32'hCAFEF00D; periph_size = 3'd4;
    set_ready(1'b0);
    send_byte(8'h80); send_byte(8'h66);
    wait_tx_valid("rst_rep");
    repeat (50) @(negedge clk_12MHz);
    check("rst_rep_txd_hold", 40'(tx_data), 40'h04);
    #2 resetn = 1'b0;
    #1;
    check("rst_rep_txv", 40'(tx_valid), 40'd0);
    check("rst_rep_txd", 40'(tx_data), 40'd0);
    @(negedge clk_12MHz);
    resetn = 1'b1;
    set_ready(1'b1);
    repeat (20) @(negedge clk_12MHz);
    check("rst_rep_dropped", 40'(rq.size()), 40'd0);
    rq.delete();

    // reset during the strobe
    send_byte(8'h80); send_byte(8'h77);
    for (int i = 0; i < 50 && !select; i++) @(negedge clk_12MHz);
    check("rst_sel_seen", 40'(select), 40'd1);
    #2 resetn = 1'b0;
    #1 check("rst_sel_drop", 40'(select), 40'd0);
    @(negedge clk_12MHz);
    resetn = 1'b1;
    repeat (20) @(negedge clk_12MHz);
    check("rst_sel_noreply", 40'(rq.size()), 40'd0);
    check("rst_sel_txv", 40'(tx_valid), 40'd0);
    rq.delete();

    set_probe(1'b0);
`ifdef BRIDGE_TIMEOUT_EN
    // gap just under the limit keeps the frame; a full gap discards it
    send_byte(8'h02); send_byte(8'h10); send_byte(8'hAA);
    repeat (TMO - 10) @(negedge clk_12MHz);
    send_byte(8'hBB);
    expect_reply("gap_short_rep", 1, 40'hA5);
    check("gap_short_bus", 40'(s_bus), 40'h0000BBAA);
    send_byte(8'h02); send_byte(8'h10); send_byte(8'hAA);
    repeat (TMO + 5) @(negedge clk_12MHz);
    check("tmo_silent", 40'(rq.size()), 40'd0);
    write_frame("tmo_next", 8'h10, 32'h00000055, 1, 32'h00000055);
`else
    // without the timeout a partial frame simply waits
    send_byte(8'h02); send_byte(8'h10); send_byte(8'hAA);
    repeat (300) @(negedge clk_12MHz);
    check("wait_silent", 40'(rq.size()), 40'd0);
    send_byte(8'hBB);
    expect_reply("wait_rep", 1, 40'hA5);
    check("wait_bus", 40'(s_bus), 40'h0000BBAA);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
